elink_tx_frame_arbiter: RTL and testbench

Round-robin frame scheduler for the e-link TX path: shares the single 18-bit write port of the TX elink FIFO between up to N_REQ CAN-channel requesters. Each granted requester's payload is wrapped into a complete frame: SOM word (code 2'b10), data words (2'b00), EOM word (2'b01). The block sits between the per-channel message buffers and the TX FIFO write side. It throttles on FIFO prog_full/full and aborts stalled frames with a watchdog.

---
 rtl/elink_tx_frame_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_elink_tx_frame_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/elink_tx_frame_arbiter.sv
// elink_tx_frame_arbiter
// Round-robin frame scheduler sharing the 18-bit TX elink FIFO write port
// between N_REQ requesters. Each frame is SOM, payload words, then EOM.
// Optional feature macro: FRAME_CHECKSUM_EN (EOM carries XOR of the payload).
module elink_tx_frame_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifoFLUSH,
  input  logic [N_REQ-1:0]      req,
  input  logic [4*N_REQ-1:0]    req_len,
  input  logic [16*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      grant,
  output logic [17:0]           fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic                  fifo_prog_full,
  output logic                  busy,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_SOM, S_DATA, S_EOM} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t            r_state;
  logic [3:0]        r_id;
  logic [3:0]        r_len;
  logic [3:0]        r_cnt;
  logic [15:0]       r_wdog;
  logic              r_abort;
  logic [3:0]        r_last_id;
  logic [N_REQ-1:0]  r_grant;

  // Requester views padded to 16 entries so a 4-bit id indexes them exactly
  logic [3:0]        w_len_arr  [16];
  logic [15:0]       w_data_arr [16];
  logic [15:0]       w_valid_arr;
  logic [15:0]       w_req_arr;

  logic              w_found;
  logic [3:0]        w_pick;
  logic [4:0]        w_idx;
  logic [N_REQ-1:0]  w_pick_oh;

  logic              w_wr_en;
  logic [17:0]       w_din;
  logic              w_accept;
  logic              w_ready_data;
  logic              w_cur_valid;
  logic [15:0]       w_cur_data;
  logic [15:0]       w_eom_data;
  logic [15:0]       w_wdog_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slot
      if (gi < N_REQ) begin : g_used
        assign w_len_arr[gi]   = req_len[4*gi +: 4];
        assign w_data_arr[gi]  = req_data[16*gi +: 16];
        assign w_valid_arr[gi] = req_valid[gi];
        assign w_req_arr[gi]   = req[gi];
      end else begin : g_pad
        assign w_len_arr[gi]   = 4'h0;
        assign w_data_arr[gi]  = 16'h0000;
        assign w_valid_arr[gi] = 1'b0;
        assign w_req_arr[gi]   = 1'b0;
      end
    end
    for (gi = 0; gi < N_REQ; gi++) begin : g_port
      assign w_pick_oh[gi] = (w_pick == 4'(gi));
      assign req_ready[gi] = w_ready_data && (r_id == 4'(gi));
    end
  endgenerate

  // Round-robin search starting just after the last served requester
  always_comb begin
    w_found = 1'b0;
    w_pick  = 4'h0;
    w_idx   = 5'h0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_last_id} + 5'(k);
      if (w_idx >= 5'(N_REQ)) begin
        w_idx = w_idx - 5'(N_REQ);
      end
      if (!w_found && w_req_arr[w_idx[3:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[3:0];
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] r_chk;

  // Running XOR of accepted payload words, cleared while idle or on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chk <= 16'h0000;
    end else if (fifoFLUSH || (r_state == S_IDLE)) begin
      r_chk <= 16'h0000;
    end else if (w_accept) begin
      r_chk <= r_chk ^ w_cur_data;
    end
  end

  assign w_eom_data = r_abort ? 16'hFFFF : r_chk;
`else
  assign w_eom_data = r_abort ? 16'hFFFF : 16'h0000;
`endif

  assign w_cur_valid  = w_valid_arr[r_id];
  assign w_cur_data   = w_data_arr[r_id];
  assign w_wdog_inc   = r_wdog + 16'd1;
  // Flush also withholds ready so no payload word is consumed unwritten
  assign w_ready_data = (r_state == S_DATA) && !fifo_full && !fifoFLUSH;

  // FIFO write port decode; nothing is written while full or flushing
  always_comb begin
    w_wr_en  = 1'b0;
    w_din    = 18'h0;
    w_accept = 1'b0;
    if (!fifoFLUSH && !fifo_full) begin
      case (r_state)
        S_SOM: begin
          w_wr_en = 1'b1;
          w_din   = {2'b10, r_id, r_len, 8'h00};
        end
        S_DATA: begin
          if (w_cur_valid) begin
            w_wr_en  = 1'b1;
            w_accept = 1'b1;
            w_din    = {2'b00, w_cur_data};
          end
        end
        S_EOM: begin
          w_wr_en = 1'b1;
          w_din   = {2'b01, w_eom_data};
        end
        default: begin
          w_wr_en = 1'b0;
        end
      endcase
    end
  end

  assign fifo_wr_en  = w_wr_en;
  assign fifo_din    = w_din;
  assign grant       = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign err_timeout = (r_state == S_EOM) && w_wr_en && r_abort;

  // Frame sequencer: arbitration, SOM/DATA/EOM progression and watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_id      <= 4'h0;
      r_len     <= 4'h0;
      r_cnt     <= 4'h0;
      r_wdog    <= 16'h0;
      r_abort   <= 1'b0;
      r_last_id <= 4'(N_REQ - 1);
      r_grant   <= '0;
    end else if (fifoFLUSH) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'h0;
      r_wdog  <= 16'h0;
      r_abort <= 1'b0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !fifo_prog_full) begin
            r_id    <= w_pick;
            r_len   <= w_len_arr[w_pick];
            r_grant <= w_pick_oh;
            r_wdog  <= 16'h0;
            r_abort <= 1'b0;
            r_state <= S_SOM;
          end
        end
        S_SOM: begin
          if (!fifo_full) begin
            r_cnt   <= r_len;
            r_state <= (r_len == 4'h0) ? S_EOM : S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_cnt  <= r_cnt - 4'd1;
            r_wdog <= 16'h0;
            if (r_cnt == 4'd1) begin
              r_state <= S_EOM;
            end
          end else if (!fifo_full) begin
            r_wdog <= w_wdog_inc;
            if (w_wdog_inc == TO_LIMIT) begin
              r_abort <= 1'b1;
              r_state <= S_EOM;
            end
          end
        end
        S_EOM: begin
          if (!fifo_full) begin
            r_last_id <= r_id;
            r_grant   <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elink_tx_frame_arbiter.sv
// Directed bench for elink_tx_frame_arbiter (N_REQ=4, TIMEOUT=4).
module tb_elink_tx_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifoFLUSH = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [15:0] req_len = 16'h0;
  logic [63:0] req_data = 64'h0;
  logic [3:0]  req_valid = 4'h0;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [17:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;
  logic        fifo_prog_full = 1'b0;
  logic        busy;
  logic        err_timeout;

  int n_checks = 0;
  int n_err    = 0;

`ifdef FRAME_CHECKSUM_EN
  localparam logic [17:0] EOM_T1 = 18'h112CB;
  localparam logic [17:0] EOM_T3 = 18'h1DDDD;
`else
  localparam logic [17:0] EOM_T1 = 18'h10000;
  localparam logic [17:0] EOM_T3 = 18'h10000;
`endif

  elink_tx_frame_arbiter #(.N_REQ(4), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifoFLUSH      (fifoFLUSH),
    .req            (req),
    .req_len        (req_len),
    .req_data       (req_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .grant          (grant),
    .fifo_din       (fifo_din),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_full      (fifo_full),
    .fifo_prog_full (fifo_prog_full),
    .busy           (busy),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks write strobe, write data, grant and busy for one cycle
  task automatic chk_cyc(input string tag, input logic exp_wr, input logic [17:0] exp_din,
                         input logic [3:0] exp_grant, input logic exp_busy);
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(exp_wr));
    chk({tag, ".din"},   32'(fifo_din),   32'(exp_din));
    chk({tag, ".grant"}, 32'(grant),      32'(exp_grant));
    chk({tag, ".busy"},  32'(busy),       32'(exp_busy));
    $display("cycle %s: wr_en=%0b din=%h grant=%b busy=%0b ready=%b err=%0b",
             tag, fifo_wr_en, fifo_din, grant, busy, req_ready, err_timeout);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #3;
    chk_cyc("reset", 1'b0, 18'h0, 4'h0, 1'b0);
    chk("reset.ready", 32'(req_ready), 32'h0);
    chk("reset.err", 32'(err_timeout), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- single request, len=2 ----------------
    tick();
    req = 4'b0001; req_len[3:0] = 4'd2; req_valid = 4'b0001; req_data[15:0] = 16'h1234;
    #1;
    chk_cyc("t1.idle", 1'b0, 18'h0, 4'h0, 1'b0);
    tick(); req = 4'b0000; #1;
    chk_cyc("t1.som", 1'b1, 18'h20200, 4'b0001, 1'b1);
    tick(); #1;
    chk_cyc("t1.d0", 1'b1, 18'h01234, 4'b0001, 1'b1);
    chk("t1.d0.ready", 32'(req_ready), 32'h1);
    tick(); req_data[15:0] = 16'h00FF; #1;
    chk_cyc("t1.d1", 1'b1, 18'h000FF, 4'b0001, 1'b1);
    tick(); #1;
    chk_cyc("t1.eom", 1'b1, EOM_T1, 4'b0001, 1'b1);
    chk("t1.eom.err", 32'(err_timeout), 32'h0);
    tick(); #1;
    chk_cyc("t1.post", 1'b0, 18'h0, 4'h0, 1'b0);

    // ---------------- round robin, len=0 everywhere ----------------
    // last served id is 0, so service order is 1,2,3,0,1
    req = 4'b1111; req_len = 16'h0000; req_valid = 4'h0;
    for (int f = 0; f < 5; f++) begin
      logic [3:0] id;
      id = 4'((f + 1) % 4);
      tick(); #1;
      chk_cyc($sformatf("rr%0d.som", f), 1'b1, {2'b10, id, 4'h0, 8'h00}, 4'(1 << id), 1'b1);
      tick(); #1;
      chk_cyc($sformatf("rr%0d.eom", f), 1'b1, 18'h10000, 4'(1 << id), 1'b1);
      tick(); #1;
      chk_cyc($sformatf("rr%0d.idle", f), 1'b0, 18'h0, 4'h0, 1'b0);
    end
    req = 4'h0;

    // ---------------- backpressure mid-DATA (last id 1 -> id 2) ----------------
    tick();
    req = 4'b0100; req_len[11:8] = 4'd3; req_valid = 4'b0100; req_data[47:32] = 16'hAAAA;
    #1;
    tick(); req = 4'h0; #1;
    chk_cyc("bp.som", 1'b1, 18'h22300, 4'b0100, 1'b1);
    tick(); #1;
    chk_cyc("bp.d0", 1'b1, 18'h0AAAA, 4'b0100, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(); fifo_full = 1'b1; req_valid = 4'h0; req_data[47:32] = 16'hBBBB; #1;
      chk_cyc($sformatf("bp.full%0d", c), 1'b0, 18'h0, 4'b0100, 1'b1);
      chk($sformatf("bp.full%0d.ready", c), 32'(req_ready), 32'h0);
    end
    // three idle cycles keep the watchdog below TIMEOUT only if full did not count
    for (int c = 0; c < 3; c++) begin
      tick(); fifo_full = 1'b0; #1;
      chk_cyc($sformatf("bp.gap%0d", c), 1'b0, 18'h0, 4'b0100, 1'b1);
      chk($sformatf("bp.gap%0d.ready", c), 32'(req_ready), 32'h4);
    end
    tick(); req_valid = 4'b0100; #1;
    chk_cyc("bp.d1", 1'b1, 18'h0BBBB, 4'b0100, 1'b1);
    tick(); req_data[47:32] = 16'hCCCC; #1;
    chk_cyc("bp.d2", 1'b1, 18'h0CCCC, 4'b0100, 1'b1);
    tick(); #1;
    chk_cyc("bp.eom", 1'b1, EOM_T3, 4'b0100, 1'b1);
    chk("bp.eom.err", 32'(err_timeout), 32'h0);
    tick(); req_valid = 4'h0; #1;
    chk_cyc("bp.post", 1'b0, 18'h0, 4'h0, 1'b0);

    // ---------------- prog_full gating (last id 2 -> id 0) ----------------
    fifo_prog_full = 1'b1; req = 4'b0001; req_len[3:0] = 4'd0;
    tick(); #1;
    chk_cyc("pf.hold0", 1'b0, 18'h0, 4'h0, 1'b0);
    tick(); fifo_prog_full = 1'b0; #1;
    chk_cyc("pf.hold1", 1'b0, 18'h0, 4'h0, 1'b0);
    tick(); req = 4'h0; #1;
    chk_cyc("pf.som", 1'b1, 18'h20000, 4'b0001, 1'b1);
    tick(); #1;
    chk_cyc("pf.eom", 1'b1, 18'h10000, 4'b0001, 1'b1);
    tick(); #1;
    chk_cyc("pf.post", 1'b0, 18'h0, 4'h0, 1'b0);

    // ---------------- watchdog timeout (last id 0 -> id 3) ----------------
    req = 4'b1000; req_len[15:12] = 4'd3; req_valid = 4'b1000; req_data[63:48] = 16'h5555;
    tick(); req = 4'h0; #1;
    chk_cyc("to.som", 1'b1, 18'h23300, 4'b1000, 1'b1);
    tick(); #1;
    chk_cyc("to.d0", 1'b1, 18'h05555, 4'b1000, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick(); req_valid = 4'h0; #1;
      chk_cyc($sformatf("to.wait%0d", c), 1'b0, 18'h0, 4'b1000, 1'b1);
      chk($sformatf("to.wait%0d.err", c), 32'(err_timeout), 32'h0);
    end
    tick(); #1;
    chk_cyc("to.eom", 1'b1, 18'h1FFFF, 4'b1000, 1'b1);
    chk("to.eom.err", 32'(err_timeout), 32'h1);
    tick(); #1;
    chk_cyc("to.post", 1'b0, 18'h0, 4'h0, 1'b0);
    chk("to.post.err", 32'(err_timeout), 32'h0);

    // ---------------- flush mid-DATA (last id 3 -> id 0) ----------------
    req = 4'b0001; req_len[3:0] = 4'd3; req_valid = 4'b0001; req_data[15:0] = 16'h7777;
    tick(); req = 4'h0; #1;
    chk_cyc("fl.som", 1'b1, 18'h20300, 4'b0001, 1'b1);
    tick(); #1;
    chk_cyc("fl.d0", 1'b1, 18'h07777, 4'b0001, 1'b1);
    tick(); fifoFLUSH = 1'b1; #1;
    chk("fl.flush.wr_en", 32'(fifo_wr_en), 32'h0);
    chk("fl.flush.din", 32'(fifo_din), 32'h0);
    tick(); fifoFLUSH = 1'b0; #1;
    chk_cyc("fl.after", 1'b0, 18'h0, 4'h0, 1'b0);
    tick(); #1;
    chk_cyc("fl.after2", 1'b0, 18'h0, 4'h0, 1'b0);

    // ---------------- reset mid-frame (last id still 3, req 1 -> id 1) ----------------
    req = 4'b0010; req_len[7:4] = 4'd2; req_valid = 4'b0010; req_data[31:16] = 16'h9ABC;
    tick(); req = 4'h0; #1;
    chk_cyc("rs.som", 1'b1, 18'h21200, 4'b0010, 1'b1);
    tick(); #1;
    chk_cyc("rs.d0", 1'b1, 18'h09ABC, 4'b0010, 1'b1);
    rst = 1'b0; #1;
    chk_cyc("rs.inreset", 1'b0, 18'h0, 4'h0, 1'b0);
    chk("rs.inreset.ready", 32'(req_ready), 32'h0);
    chk("rs.inreset.err", 32'(err_timeout), 32'h0);
    req = 4'b1111; req_len = 16'h0000; req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    tick(); req = 4'h0; #1;
    chk_cyc("rs.first", 1'b1, 18'h20000, 4'b0001, 1'b1);
    tick(); #1;
    chk_cyc("rs.eom", 1'b1, 18'h10000, 4'b0001, 1'b1);
    tick(); #1;
    chk_cyc("rs.post", 1'b0, 18'h0, 4'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
